cache_mem_arbiter: RTL and testbench

- Sits directly downstream of the core's icache and dcache cmd/rsp ports.
- Merges both request streams into one memory command/response port that feeds the RAM model, or later the AXI bridge.
- Tracks in-flight requests in a small in-order tag FIFO and routes each memory response back to the port that issued it.
- Extracts the 32-bit instruction word for the icache.

---
 rtl/cache_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Merges the core's icache and dcache command streams onto one memory port.
//   Each accepted command is recorded as a tag {src, addr[2], wen} in an in-order
//   FIFO. Each memory response pops the head tag and is routed back, registered,
//   to the issuing cache. The icache receives the 32-bit word selected by addr[2].
//
// Ports
//   clk_i, reset_i              clock, synchronous active-high reset
//   icache_cmd_*_i/o            icache request (valid/ready, addr)
//   icache_rsp_*_o              icache response pulse + 32-bit instruction word
//   dcache_cmd_*_i/o            dcache request (valid/ready, addr, wen, wdata, wstrb, size)
//   dcache_rsp_*_o              dcache response pulse + 64-bit data (0 on write acks)
//   mem_cmd_*_o / mem_cmd_ready_i  merged memory request
//   mem_rsp_*_i                 memory response, in order, no backpressure
//   rsp_orphan_err_o            sticky: response seen with nothing outstanding
module cache_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              icache_cmd_valid_i,
    output logic              icache_cmd_ready_o,
    input  logic [ADDR_W-1:0] icache_cmd_payload_addr_i,
    output logic              icache_rsp_valid_o,
    output logic [31:0]       icache_rsp_payload_data_o,
    input  logic              dcache_cmd_valid_i,
    output logic              dcache_cmd_ready_o,
    input  logic [ADDR_W-1:0] dcache_cmd_payload_addr_i,
    input  logic              dcache_cmd_payload_wen_i,
    input  logic [63:0]       dcache_cmd_payload_wdata_i,
    input  logic [7:0]        dcache_cmd_payload_wstrb_i,
    input  logic [2:0]        dcache_cmd_payload_size_i,
    output logic              dcache_rsp_valid_o,
    output logic [63:0]       dcache_rsp_payload_data_o,
    output logic              mem_cmd_valid_o,
    input  logic              mem_cmd_ready_i,
    output logic [ADDR_W-1:0] mem_cmd_payload_addr_o,
    output logic              mem_cmd_payload_wen_o,
    output logic [63:0]       mem_cmd_payload_wdata_o,
    output logic [7:0]        mem_cmd_payload_wstrb_o,
    output logic [2:0]        mem_cmd_payload_size_o,
    input  logic              mem_rsp_valid_i,
    input  logic [63:0]       mem_rsp_payload_data_i,
    output logic              rsp_orphan_err_o
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t                     state_q, state_d;
    logic                       last_d_q;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q;
    logic [MAX_OUTSTANDING-1:0] tag_src_q, tag_a2_q, tag_wen_q;

    logic        icache_rsp_valid_q, dcache_rsp_valid_q, orphan_q;
    logic [31:0] icache_rsp_data_q;
    logic [63:0] dcache_rsp_data_q;

    logic fifo_empty, fifo_full, rsp_pop, rsp_orphan;
    logic grant_i, grant_d, push;

    assign fifo_empty = (count_q == '0);
    assign rsp_pop    = mem_rsp_valid_i & ~fifo_empty;
    assign rsp_orphan = mem_rsp_valid_i & fifo_empty;
    // A pop in the same cycle frees a slot, so "full" is evaluated after the pop.
    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING)) & ~rsp_pop;

    // Grant selection and FSM next state. While full nothing issues and the
    // state (including a frozen HOLD grant) is kept.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                // dcache has priority unless it won the previous acceptance
                // and icache is waiting.
                if (dcache_cmd_valid_i && !(last_d_q && icache_cmd_valid_i))
                    grant_d = 1'b1;
                else if (icache_cmd_valid_i)
                    grant_i = 1'b1;
                if (!fifo_full && !mem_cmd_ready_i) begin
                    if (grant_d)      state_d = HOLD_D;
                    else if (grant_i) state_d = HOLD_I;
                end
            end
            HOLD_I: begin
                grant_i = 1'b1;
                if (!fifo_full && mem_cmd_ready_i) state_d = IDLE;
            end
            HOLD_D: begin
                grant_d = 1'b1;
                if (!fifo_full && mem_cmd_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_cmd_valid_o    = (grant_i | grant_d) & ~fifo_full;
    assign push               = mem_cmd_valid_o & mem_cmd_ready_i;
    assign icache_cmd_ready_o = grant_i & mem_cmd_ready_i & ~fifo_full;
    assign dcache_cmd_ready_o = grant_d & mem_cmd_ready_i & ~fifo_full;

    always_comb begin
        mem_cmd_payload_addr_o  = '0;
        mem_cmd_payload_wen_o   = 1'b0;
        mem_cmd_payload_wdata_o = '0;
        mem_cmd_payload_wstrb_o = '0;
        mem_cmd_payload_size_o  = '0;
        if (grant_d) begin
            mem_cmd_payload_addr_o  = dcache_cmd_payload_addr_i;
            mem_cmd_payload_wen_o   = dcache_cmd_payload_wen_i;
            mem_cmd_payload_wdata_o = dcache_cmd_payload_wdata_i;
            mem_cmd_payload_wstrb_o = dcache_cmd_payload_wstrb_i;
            mem_cmd_payload_size_o  = dcache_cmd_payload_size_i;
        end else if (grant_i) begin
            mem_cmd_payload_addr_o  = icache_cmd_payload_addr_i;
            mem_cmd_payload_size_o  = 3'd2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                last_d_q <= grant_d;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rsp_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(rsp_pop);
        end
    end

    // Tag storage needs no reset: entries are only read when count_q says valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_src_q[wr_ptr_q] <= grant_d;
            tag_a2_q[wr_ptr_q]  <= mem_cmd_payload_addr_o[2];
            tag_wen_q[wr_ptr_q] <= mem_cmd_payload_wen_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            icache_rsp_valid_q <= 1'b0;
            dcache_rsp_valid_q <= 1'b0;
            icache_rsp_data_q  <= '0;
            dcache_rsp_data_q  <= '0;
            orphan_q           <= 1'b0;
        end else begin
            icache_rsp_valid_q <= 1'b0;
            dcache_rsp_valid_q <= 1'b0;
            if (rsp_orphan) orphan_q <= 1'b1;
            if (rsp_pop) begin
                if (tag_src_q[rd_ptr_q]) begin
                    dcache_rsp_valid_q <= 1'b1;
                    dcache_rsp_data_q  <= tag_wen_q[rd_ptr_q] ? 64'd0 : mem_rsp_payload_data_i;
                end else begin
                    icache_rsp_valid_q <= 1'b1;
                    icache_rsp_data_q  <= tag_a2_q[rd_ptr_q] ? mem_rsp_payload_data_i[63:32]
                                                             : mem_rsp_payload_data_i[31:0];
                end
            end
        end
    end

    assign icache_rsp_valid_o        = icache_rsp_valid_q;
    assign icache_rsp_payload_data_o = icache_rsp_data_q;
    assign dcache_rsp_valid_o        = dcache_rsp_valid_q;
    assign dcache_rsp_payload_data_o = dcache_rsp_data_q;
    assign rsp_orphan_err_o          = orphan_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by a random phase,
// all checked cycle by cycle against a queue-based reference model.
module tb_cache_mem_arbiter;
    localparam int M  = 4;
    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          iv = 1'b0, dv = 1'b0, ird, drd;
    logic [AW-1:0] ia = '0, da = '0;
    logic          dwen = 1'b0;
    logic [63:0]   dwdata = '0;
    logic [7:0]    dstrb = '0;
    logic [2:0]    dsize = '0;
    logic          irv, drv, mcv, mwen, orphan_o;
    logic [31:0]   irdata;
    logic [63:0]   drdata, mwdata;
    logic [AW-1:0] maddr;
    logic [7:0]    mstrb;
    logic [2:0]    msize;
    logic          mrdy = 1'b0, mrv = 1'b0;
    logic [63:0]   mrdata = '0;

    int total = 0;
    int bad   = 0;

    cache_mem_arbiter #(.MAX_OUTSTANDING(M), .ADDR_W(AW)) dut (
        .clk_i(clk), .reset_i(reset),
        .icache_cmd_valid_i(iv), .icache_cmd_ready_o(ird),
        .icache_cmd_payload_addr_i(ia),
        .icache_rsp_valid_o(irv), .icache_rsp_payload_data_o(irdata),
        .dcache_cmd_valid_i(dv), .dcache_cmd_ready_o(drd),
        .dcache_cmd_payload_addr_i(da), .dcache_cmd_payload_wen_i(dwen),
        .dcache_cmd_payload_wdata_i(dwdata), .dcache_cmd_payload_wstrb_i(dstrb),
        .dcache_cmd_payload_size_i(dsize),
        .dcache_rsp_valid_o(drv), .dcache_rsp_payload_data_o(drdata),
        .mem_cmd_valid_o(mcv), .mem_cmd_ready_i(mrdy),
        .mem_cmd_payload_addr_o(maddr), .mem_cmd_payload_wen_o(mwen),
        .mem_cmd_payload_wdata_o(mwdata), .mem_cmd_payload_wstrb_o(mstrb),
        .mem_cmd_payload_size_o(msize),
        .mem_rsp_valid_i(mrv), .mem_rsp_payload_data_i(mrdata),
        .rsp_orphan_err_o(orphan_o)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding requests as a queue, the frozen grant
    // (0 none, 1 icache, 2 dcache), who won last, and expected response regs.
    typedef struct packed { bit d; bit a2; bit wen; } tag_t;
    tag_t        q[$];
    int          hold;
    bit          last_d, m_orphan, e_irv, e_drv;
    logic [31:0] e_ird;
    logic [63:0] e_drd;
    int          acc_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hold = 0; last_d = 0; m_orphan = 0;
        e_irv = 0; e_drv = 0; e_ird = '0; e_drd = '0;
    endtask

    // One clock cycle: inputs are already set; check at mid-cycle, advance the
    // model, cross the edge, then retire accepted requests and response pulses.
    task automatic tick();
        bit   full, acc;
        int   g;
        tag_t t;
        acc = 0;
        #4;
        if (reset) begin
            model_reset();
        end else begin
            full = (q.size() == M) && !mrv;
            g = hold;
            if (g == 0) begin
                if (dv && !(last_d && iv)) g = 2;
                else if (iv)               g = 1;
            end
            if (full) g = 0;
            chk("mem_cmd_valid", 64'(mcv), 64'(g != 0));
            chk("icache_ready", 64'(ird), 64'(g == 1 && mrdy));
            chk("dcache_ready", 64'(drd), 64'(g == 2 && mrdy));
            if (g == 2) begin
                chk("d_addr", maddr, da);
                chk("d_wen", 64'(mwen), 64'(dwen));
                chk("d_wdata", mwdata, dwdata);
                chk("d_wstrb", 64'(mstrb), 64'(dstrb));
                chk("d_size", 64'(msize), 64'(dsize));
            end else if (g == 1) begin
                chk("i_addr", maddr, ia);
                chk("i_wen", 64'(mwen), 64'd0);
                chk("i_wdata", mwdata, 64'd0);
                chk("i_wstrb", 64'(mstrb), 64'd0);
                chk("i_size", 64'(msize), 64'd2);
            end
            chk("icache_rsp_valid", 64'(irv), 64'(e_irv));
            chk("icache_rsp_data", 64'(irdata), 64'(e_ird));
            chk("dcache_rsp_valid", 64'(drv), 64'(e_drv));
            chk("dcache_rsp_data", drdata, e_drd);
            chk("orphan", 64'(orphan_o), 64'(m_orphan));
            e_irv = 0; e_drv = 0;
            if (mrv) begin
                if (q.size() == 0) m_orphan = 1;
                else begin
                    t = q.pop_front();
                    if (t.d) begin e_drv = 1; e_drd = t.wen ? 64'd0 : mrdata; end
                    else begin e_irv = 1; e_ird = t.a2 ? mrdata[63:32] : mrdata[31:0]; end
                end
            end
            acc = (g != 0) && mrdy;
            if (acc) begin
                if (g == 2) q.push_back('{d: 1'b1, a2: da[2], wen: dwen});
                else        q.push_back('{d: 1'b0, a2: ia[2], wen: 1'b0});
                last_d = (g == 2);
                hold = 0;
                acc_log.push_back(g);
            end else if (g != 0) begin
                hold = g;
            end
        end
        @(posedge clk); #1;
        if (acc && hold == 0 && acc_log[acc_log.size()-1] == 2) dv = 0;
        if (acc && hold == 0 && acc_log[acc_log.size()-1] == 1) iv = 0;
        mrv = 0;
    endtask

    task automatic rsp(input logic [63:0] d);
        mrv = 1; mrdata = d; tick();
    endtask

    initial begin
        logic [63:0] w0, w1;
        int n;
        model_reset();
        // Reset state
        reset = 1; tick(); tick(); reset = 0;
        chk("rst_mem_valid", 64'(mcv), 64'd0);
        chk("rst_iready", 64'(ird), 64'd0);
        chk("rst_dready", 64'(drd), 64'd0);
        chk("rst_irv", 64'(irv), 64'd0);
        chk("rst_drv", 64'(drv), 64'd0);
        chk("rst_irdata", 64'(irdata), 64'd0);
        chk("rst_drdata", drdata, 64'd0);
        chk("rst_orphan", 64'(orphan_o), 64'd0);

        // Single fetch, upper word selected by addr[2]
        mrdy = 1; iv = 1; ia = 64'h8000_0004; tick();
        rsp(64'h1111_2222_3333_4444);
        chk("fetch_valid", 64'(irv), 64'd1);
        chk("fetch_word", 64'(irdata), 64'h1111_2222);
        tick();

        // Both valid together: dcache first, then icache; in-order routing
        iv = 1; ia = 64'h0; dv = 1; da = 64'h100; dwen = 0; dsize = 3; dstrb = 8'hFF; dwdata = '0;
        tick(); tick();
        w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
        rsp(w0);
        chk("order_d_valid", 64'(drv), 64'd1);
        chk("order_d_data", drdata, w0);
        rsp(w1);
        chk("order_i_valid", 64'(irv), 64'd1);
        chk("order_i_data", 64'(irdata), 64'(w1[31:0]));
        tick();

        // Both continuously requesting: acceptances alternate D, I, D, I
        acc_log.delete();
        for (int k = 0; k < 4; k++) begin
            if (!iv) begin iv = 1; ia = 64'h1000 + 64'(k * 8); end
            if (!dv) begin dv = 1; da = 64'h2000 + 64'(k * 8); end
            tick();
        end
        iv = 0; dv = 0;
        chk("alt_count", 64'(acc_log.size()), 64'd4);
        for (int k = 0; k < acc_log.size() && k < 4; k++)
            chk("alt_src", 64'(acc_log[k]), (k % 2 == 0) ? 64'd2 : 64'd1);
        for (int k = 0; k < 4; k++) rsp({$urandom, $urandom});
        tick();

        // Stalled dcache write holds its payload while icache waits
        mrdy = 0; dv = 1; da = 64'h200; dwen = 1; dstrb = 8'h0F; dsize = 3; dwdata = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        iv = 1; ia = 64'h300; tick(); tick();
        chk("hold_addr", maddr, 64'h200);
        chk("hold_wstrb", 64'(mstrb), 64'h0F);
        chk("hold_no_iready", 64'(ird), 64'd0);
        mrdy = 1; tick(); tick();
        rsp({$urandom, $urandom});
        chk("wack_data", drdata, 64'd0);
        rsp({$urandom, $urandom});
        tick();

        // Fill the tag FIFO, then a response in the same cycle lets a 5th in
        dwen = 0; dsize = 3; dstrb = 8'hFF;
        for (int k = 0; k < 4; k++) begin dv = 1; da = 64'h4000 + 64'(k * 8); tick(); end
        iv = 1; ia = 64'h5004; dv = 1; da = 64'h6000; tick();
        chk("full_iready", 64'(ird), 64'd0);
        chk("full_dready", 64'(drd), 64'd0);
        chk("full_mvalid", 64'(mcv), 64'd0);
        w0 = {$urandom, $urandom};
        mrv = 1; mrdata = w0;
        #4;
        chk("pop_push_iready", 64'(ird), 64'd1);
        #(-4ns + 4ns);
        tick();
        for (int k = 0; k < 10 && (q.size() > 0 || iv || dv); k++) begin
            if (q.size() > 0) begin mrv = 1; mrdata = {$urandom, $urandom}; end
            tick();
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (!iv && $urandom_range(0, 2) == 0) begin iv = 1; ia = {$urandom, $urandom}; end
            if (!dv && $urandom_range(0, 2) == 0) begin
                dv = 1; da = {$urandom, $urandom}; dwen = $urandom_range(0, 1) == 1;
                dwdata = {$urandom, $urandom}; dstrb = 8'($urandom); dsize = 3'($urandom);
            end
            mrdy = $urandom_range(0, 3) != 0;
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin mrv = 1; mrdata = {$urandom, $urandom}; end
            tick();
        end
        mrdy = 1;
        n = 0;
        while ((q.size() > 0 || iv || dv || hold != 0) && n < 40) begin
            if (q.size() > 0) begin mrv = 1; mrdata = {$urandom, $urandom}; end
            tick(); n++;
        end
        chk("drain_done", 64'(q.size() == 0 && !iv && !dv), 64'd1);
        tick();

        // Orphan response together with a push: push proceeds, flag sets
        iv = 1; ia = 64'h7000; mrv = 1; mrdata = {$urandom, $urandom}; tick();
        chk("orphan_set", 64'(orphan_o), 64'd1);
        chk("orphan_no_irv", 64'(irv), 64'd0);
        chk("orphan_no_drv", 64'(drv), 64'd0);
        rsp(64'hAAAA_BBBB_CCCC_DDDD);
        chk("after_orphan_iword", 64'(irdata), 64'hCCCC_DDDD);
        tick(); tick();
        chk("orphan_sticky", 64'(orphan_o), 64'd1);

        // Reset mid-operation flushes the FIFO and clears the flag
        dv = 1; da = 64'h8000; dwen = 0; tick();
        dv = 1; da = 64'h8008; tick();
        dv = 0; iv = 0;
        reset = 1; tick(); reset = 0;
        chk("mid_rst_orphan", 64'(orphan_o), 64'd0);
        chk("mid_rst_drdata", drdata, 64'd0);
        chk("mid_rst_irdata", 64'(irdata), 64'd0);
        rsp({$urandom, $urandom});
        chk("post_rst_orphan", 64'(orphan_o), 64'd1);
        chk("post_rst_no_drv", 64'(drv), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
